glm_domain_pipe: RTL

- Registered, multi-lane successor to the single-nibble GLM domain-function cells used in the masked PRINCE S-box.
- Each lane evaluates the fixed 8-output domain polynomial (s[3:0], t[3:0]) on one 4-bit share selection.
- A parameter picks, per bit, whether that bit comes from the x-share or the y-share, so one module covers every domain pattern (xxxx, yyxy, ...).
- Two register stages: monomials, then XOR compression. This gives a glitch barrier between AND and XOR layers. Valid/hold control lets the round controller stall it.

---
 rtl/glm_domain_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/glm_domain_pipe.sv
// Multi-lane GLM domain polynomial for the masked PRINCE S-box.
// Stage 1 holds AND-only monomials and stage 2 holds their XOR compression, so the two layers are separated by a register.
module glm_domain_pipe #(
    parameter int          N_LANES  = 16,
    parameter logic [3:0]  DOM_MASK = 4'b0100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,
    input  logic                   in_valid,
    input  logic [4*N_LANES-1:0]   x_sh,
    input  logic [4*N_LANES-1:0]   y_sh,
    output logic                   out_valid,
    output logic [4*N_LANES-1:0]   s_out,
    output logic [4*N_LANES-1:0]   t_out
);

    localparam int W = 4*N_LANES;

    // Indices of the monomials held in stage 1.
    localparam int L1   = 0;
    localparam int L3   = 1;
    localparam int Q01  = 2;
    localparam int Q02  = 3;
    localparam int Q03  = 4;
    localparam int Q12  = 5;
    localparam int Q13  = 6;
    localparam int Q23  = 7;
    localparam int C012 = 8;
    localparam int C013 = 9;
    localparam int C023 = 10;
    localparam int C123 = 11;

    logic [N_LANES-1:0] a0, a1, a2, a3;

    // DOM_MASK is a constant, so each share selection reduces to plain wiring.
    for (genvar l = 0; l < N_LANES; l++) begin : g_sel
        assign a0[l] = DOM_MASK[0] ? x_sh[4*l+0] : y_sh[4*l+0];
        assign a1[l] = DOM_MASK[1] ? x_sh[4*l+1] : y_sh[4*l+1];
        assign a2[l] = DOM_MASK[2] ? x_sh[4*l+2] : y_sh[4*l+2];
        assign a3[l] = DOM_MASK[3] ? x_sh[4*l+3] : y_sh[4*l+3];
    end

    logic [N_LANES-1:0][11:0] st1_d, st1_q;
    logic [W-1:0]             s_d, s_q, t_d, t_q;
    logic                     v1_q, ov_q;

    always_comb begin
        st1_d = '0;
        for (int l = 0; l < N_LANES; l++) begin
            st1_d[l][L1]   = a1[l];
            st1_d[l][L3]   = a3[l];
            st1_d[l][Q01]  = a0[l] & a1[l];
            st1_d[l][Q02]  = a0[l] & a2[l];
            st1_d[l][Q03]  = a0[l] & a3[l];
            st1_d[l][Q12]  = a1[l] & a2[l];
            st1_d[l][Q13]  = a1[l] & a3[l];
            st1_d[l][Q23]  = a2[l] & a3[l];
            st1_d[l][C012] = a0[l] & a1[l] & a2[l];
            st1_d[l][C013] = a0[l] & a1[l] & a3[l];
            st1_d[l][C023] = a0[l] & a2[l] & a3[l];
            st1_d[l][C123] = a1[l] & a2[l] & a3[l];
        end
    end

    always_comb begin
        s_d = '0;
        t_d = '0;
        for (int l = 0; l < N_LANES; l++) begin
            s_d[4*l+0] = st1_q[l][C012] ^ st1_q[l][Q23] ^ st1_q[l][Q01];
            s_d[4*l+1] = st1_q[l][C012] ^ st1_q[l][C123] ^ st1_q[l][Q13];
            s_d[4*l+2] = st1_q[l][C013] ^ st1_q[l][C123] ^ st1_q[l][Q03] ^ st1_q[l][Q13];
            s_d[4*l+3] = st1_q[l][L1] ^ st1_q[l][Q01] ^ st1_q[l][Q12] ^ st1_q[l][Q13]
                       ^ st1_q[l][Q23] ^ st1_q[l][C012] ^ st1_q[l][C013] ^ st1_q[l][C023];
            t_d[4*l+0] = st1_q[l][C013] ^ st1_q[l][C023] ^ st1_q[l][Q23] ^ st1_q[l][Q01];
            t_d[4*l+1] = st1_q[l][C012] ^ st1_q[l][Q13] ^ st1_q[l][Q23];
            t_d[4*l+2] = st1_q[l][C012] ^ st1_q[l][C013] ^ st1_q[l][Q02] ^ st1_q[l][Q13];
            t_d[4*l+3] = st1_q[l][L3] ^ st1_q[l][Q01] ^ st1_q[l][Q03] ^ st1_q[l][Q13]
                       ^ st1_q[l][Q23] ^ st1_q[l][C012] ^ st1_q[l][C023] ^ st1_q[l][C123];
        end
    end

    // Data loads on every non-hold edge; out_valid alone qualifies the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_q <= '0;
            s_q   <= '0;
            t_q   <= '0;
            v1_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else if (!hold) begin
            st1_q <= st1_d;
            s_q   <= s_d;
            t_q   <= t_d;
            v1_q  <= in_valid;
            ov_q  <= v1_q;
        end
    end

    assign out_valid = ov_q;
    assign s_out     = s_q;
    assign t_out     = t_q;

endmodule
